// File: rtl/video_to_fifo_ctrl.sv
// Packs a 24-bit RGB pixel stream four-per-word into 128-bit write-FIFO words and
// requests one AXI write burst per completed line; vsync rise clears the FIFO and framing.
module video_to_fifo_ctrl #(
    parameter int          AXI4_DATA_WIDTH = 128,
    parameter logic [11:0] H_DISP          = 12'd2880,
    parameter logic [11:0] V_DISP          = 12'd1080,
    parameter int          FIFO_RST_CYCLES = 8,
    parameter int          PEND_W          = 4
) (
    input  logic                       video_clk,
    input  logic                       video_rst,
    input  logic                       video_vs_in,
    input  logic                       video_hs_in,
    input  logic                       video_de_in,
    input  logic [23:0]                video_data_in,
    output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
    output logic                       fifo_rst,
    output logic                       AXI_FULL_BURST_VALID,
    input  logic                       AXI_FULL_BURST_READY,
    output logic [11:0]                line_cnt,
    output logic                       overflow,
    output logic                       line_err
);

    logic                       de_d1;
    logic                       vs_d1;
    logic [7:0]                 rst_cnt;
    logic [1:0]                 pack_k;
    logic [AXI4_DATA_WIDTH-1:0] pack_buf;
    logic [AXI4_DATA_WIDTH-1:0] pack_next;
    logic [12:0]                pix_cnt;
    logic                       line_done_d1;
    logic [PEND_W-1:0]          pending;
    logic [PEND_W-1:0]          pending_next;
    logic                       pend_ovf;
    logic                       frame_start;
    logic                       pix_take;
    logic                       line_end;
    logic                       burst_hs;
    logic                       wr_req;
    logic [AXI4_DATA_WIDTH-1:0] wr_word;
    logic                       unused_hs;

    assign unused_hs   = video_hs_in;
    assign fifo_rst    = (rst_cnt != 8'd0);
    assign frame_start = video_vs_in & ~vs_d1;
    // Nothing is packed or framed while the FIFO is being cleared
    assign pix_take    = video_de_in & ~fifo_rst & ~frame_start;
    assign line_end    = ~video_de_in & de_d1 & ~fifo_rst & ~frame_start;
    assign burst_hs    = AXI_FULL_BURST_VALID & AXI_FULL_BURST_READY;

    always_comb begin
        pack_next = pack_buf;
        case (pack_k)
            2'd0:    pack_next[AXI4_DATA_WIDTH-1  -: 32] = {8'h00, video_data_in};
            2'd1:    pack_next[AXI4_DATA_WIDTH-33 -: 32] = {8'h00, video_data_in};
            2'd2:    pack_next[AXI4_DATA_WIDTH-65 -: 32] = {8'h00, video_data_in};
            default: pack_next[AXI4_DATA_WIDTH-97 -: 32] = {8'h00, video_data_in};
        endcase
    end

    always_comb begin
        wr_req  = (pix_take && pack_k == 2'd3) || (line_end && pack_k != 2'd0);
        wr_word = pix_take ? pack_next : pack_buf;
    end

    // Line completion and handshake in the same cycle cancel out
    always_comb begin
        pending_next = pending;
        pend_ovf     = 1'b0;
        if (line_done_d1 && !burst_hs) begin
            if (pending == '1)
                pend_ovf = 1'b1;
            else
                pending_next = pending + 1'b1;
        end else if (!line_done_d1 && burst_hs) begin
            pending_next = pending - 1'b1;
        end
    end

    always_ff @(posedge video_clk or posedge video_rst) begin
        if (video_rst) begin
            de_d1                <= 1'b0;
            vs_d1                <= 1'b0;
            rst_cnt              <= 8'd0;
            pack_k               <= 2'd0;
            pack_buf             <= '0;
            pix_cnt              <= 13'd0;
            line_done_d1         <= 1'b0;
            pending              <= '0;
            AXI_FULL_BURST_VALID <= 1'b0;
            fifo_data_out        <= '0;
            fifo_wr_en           <= 1'b0;
            line_cnt             <= 12'd0;
            overflow             <= 1'b0;
            line_err             <= 1'b0;
        end else begin
            de_d1      <= video_de_in;
            vs_d1      <= video_vs_in;
            fifo_wr_en <= 1'b0;
            if (frame_start) begin
                rst_cnt              <= 8'(FIFO_RST_CYCLES);
                pack_k               <= 2'd0;
                pack_buf             <= '0;
                pix_cnt              <= 13'd0;
                line_done_d1         <= 1'b0;
                pending              <= '0;
                AXI_FULL_BURST_VALID <= 1'b0;
                line_cnt             <= 12'd0;
                overflow             <= 1'b0;
                line_err             <= 1'b0;
            end else begin
                if (rst_cnt != 8'd0)
                    rst_cnt <= rst_cnt - 8'd1;
                line_done_d1         <= line_end;
                pending              <= pending_next;
                AXI_FULL_BURST_VALID <= (pending_next != '0);
                if (pend_ovf)
                    overflow <= 1'b1;

                if (wr_req) begin
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end else begin
                        fifo_wr_en    <= 1'b1;
                        fifo_data_out <= wr_word;
                    end
                end

                if (pix_take) begin
                    if (pix_cnt != '1)
                        pix_cnt <= pix_cnt + 13'd1;
                    if (pack_k == 2'd3) begin
                        pack_k   <= 2'd0;
                        pack_buf <= '0;
                    end else begin
                        pack_k   <= pack_k + 2'd1;
                        pack_buf <= pack_next;
                    end
                end else if (line_end) begin
                    pack_k   <= 2'd0;
                    pack_buf <= '0;
                    pix_cnt  <= 13'd0;
                    if (pix_cnt != {1'b0, H_DISP} || line_cnt >= V_DISP)
                        line_err <= 1'b1;
                    if (line_cnt != '1)
                        line_cnt <= line_cnt + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// Directed bench for video_to_fifo_ctrl: packing, flush, burst request/pending,
// FIFO-full drop, frame-start clear and full-length line framing.
module tb_video_to_fifo_ctrl;

    logic         video_clk = 1'b0;
    logic         video_rst;
    logic         video_vs_in;
    logic         video_hs_in;
    logic         video_de_in;
    logic [23:0]  video_data_in;
    logic [127:0] fifo_data_out;
    logic         fifo_wr_en;
    logic         fifo_full;
    logic         fifo_rst;
    logic         AXI_FULL_BURST_VALID;
    logic         AXI_FULL_BURST_READY;
    logic [11:0]  line_cnt;
    logic         overflow;
    logic         line_err;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] wr_q[$];
    int           hs_cnt      = 0;
    int           rst_cycles  = 0;

    video_to_fifo_ctrl dut (
        .video_clk            (video_clk),
        .video_rst            (video_rst),
        .video_vs_in          (video_vs_in),
        .video_hs_in          (video_hs_in),
        .video_de_in          (video_de_in),
        .video_data_in        (video_data_in),
        .fifo_data_out        (fifo_data_out),
        .fifo_wr_en           (fifo_wr_en),
        .fifo_full            (fifo_full),
        .fifo_rst             (fifo_rst),
        .AXI_FULL_BURST_VALID (AXI_FULL_BURST_VALID),
        .AXI_FULL_BURST_READY (AXI_FULL_BURST_READY),
        .line_cnt             (line_cnt),
        .overflow             (overflow),
        .line_err             (line_err)
    );

    always #5 video_clk = ~video_clk;

    always @(negedge video_clk) begin
        if (fifo_wr_en)
            wr_q.push_back(fifo_data_out);
        if (AXI_FULL_BURST_VALID && AXI_FULL_BURST_READY)
            hs_cnt++;
        if (fifo_rst)
            rst_cycles++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic send_line(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            video_de_in   = 1'b1;
            video_data_in = base + 24'(i);
            tick();
        end
        video_de_in   = 1'b0;
        video_data_in = 24'h0;
    endtask

    task automatic wait_rst_done();
        int n = 0;
        while (fifo_rst && n < 40) begin
            tick();
            n++;
        end
        check("rst_done", {127'h0, fifo_rst}, 128'h0);
    endtask

    initial begin
        video_rst            = 1'b1;
        video_vs_in          = 1'b0;
        video_hs_in          = 1'b0;
        video_de_in          = 1'b0;
        video_data_in        = 24'h0;
        fifo_full            = 1'b0;
        AXI_FULL_BURST_READY = 1'b0;

        // reset with toggling inputs
        for (int i = 0; i < 6; i++) begin
            video_vs_in          = 1'($urandom);
            video_hs_in          = 1'($urandom);
            video_de_in          = 1'($urandom);
            video_data_in        = 24'($urandom);
            fifo_full            = 1'($urandom);
            AXI_FULL_BURST_READY = 1'($urandom);
            tick();
        end
        check("in_rst_data", fifo_data_out, 128'h0);
        check("in_rst_ctl", {111'h0, fifo_wr_en, fifo_rst, AXI_FULL_BURST_VALID, line_cnt, overflow, line_err}, 128'h0);
        video_vs_in = 1'b0; video_hs_in = 1'b0; video_de_in = 1'b0;
        video_data_in = 24'h0; fifo_full = 1'b0; AXI_FULL_BURST_READY = 1'b1;
        tick();
        video_rst = 1'b0;
        tick();
        check("post_rst_data", fifo_data_out, 128'h0);
        check("post_rst_ctl", {111'h0, fifo_wr_en, fifo_rst, AXI_FULL_BURST_VALID, line_cnt, overflow, line_err}, 128'h0);
        wr_q.delete();

        // 8-pixel line
        send_line(8, 24'h000001);
        tick();
        check("a_valid_e1", {127'h0, AXI_FULL_BURST_VALID}, 128'h0);
        check("a_wr_count", 128'(wr_q.size()), 128'd2);
        if (wr_q.size() == 2) begin
            check("a_word0", wr_q[0], 128'h00000001_00000002_00000003_00000004);
            check("a_word1", wr_q[1], 128'h00000005_00000006_00000007_00000008);
        end
        tick();
        check("a_valid_e2", {127'h0, AXI_FULL_BURST_VALID}, 128'h1);
        tick();
        check("a_valid_e3", {127'h0, AXI_FULL_BURST_VALID}, 128'h0);
        check("a_line_cnt", 128'(line_cnt), 128'd1);
        check("a_line_err", {127'h0, line_err}, 128'h1);
        check("a_overflow", {127'h0, overflow}, 128'h0);

        // 6-pixel line, partial word flushed at line end
        wr_q.delete();
        send_line(6, 24'h000001);
        tick();
        check("b_flush_wr", {127'h0, fifo_wr_en}, 128'h1);
        check("b_flush_data", fifo_data_out, 128'h00000005_00000006_00000000_00000000);
        repeat (3) tick();
        check("b_line_cnt", 128'(line_cnt), 128'd2);

        // three lines with READY low, then a fourth ending on a handshake
        AXI_FULL_BURST_READY = 1'b0;
        hs_cnt = 0;
        for (int l = 0; l < 3; l++) begin
            send_line(4, 24'h000100);
            repeat (2) tick();
        end
        repeat (3) tick();
        check("c_valid_held", {127'h0, AXI_FULL_BURST_VALID}, 128'h1);
        check("c_no_hs", 128'(hs_cnt), 128'd0);
        send_line(4, 24'h000200);
        tick();
        AXI_FULL_BURST_READY = 1'b1;
        repeat (3) tick();
        check("c_valid_p3", {127'h0, AXI_FULL_BURST_VALID}, 128'h1);
        tick();
        check("c_valid_drop", {127'h0, AXI_FULL_BURST_VALID}, 128'h0);
        check("c_hs_count", 128'(hs_cnt), 128'd4);
        check("c_line_cnt", 128'(line_cnt), 128'd6);

        // FIFO full during the second word
        wr_q.delete();
        for (int i = 0; i < 8; i++) begin
            fifo_full     = (i >= 4);
            video_de_in   = 1'b1;
            video_data_in = 24'(i + 1);
            tick();
        end
        video_de_in = 1'b0;
        tick();
        fifo_full = 1'b0;
        repeat (3) tick();
        check("d_wr_count", 128'(wr_q.size()), 128'd1);
        if (wr_q.size() == 1)
            check("d_word0", wr_q[0], 128'h00000001_00000002_00000003_00000004);
        check("d_overflow", {127'h0, overflow}, 128'h1);
        check("d_line_cnt", 128'(line_cnt), 128'd7);

        // vsync rise mid-line after 2 pixels
        wr_q.delete();
        rst_cycles = 0;
        send_line(2, 24'h000011);
        video_vs_in = 1'b1;
        tick();
        check("e_fifo_rst", {127'h0, fifo_rst}, 128'h1);
        check("e_clear", {124'h0, AXI_FULL_BURST_VALID, overflow, line_err, fifo_wr_en}, 128'h0);
        check("e_line_cnt0", 128'(line_cnt), 128'd0);
        video_de_in = 1'b1; video_data_in = 24'h000099;
        repeat (3) tick();
        video_de_in = 1'b0;
        video_vs_in = 1'b0;
        wait_rst_done();
        check("e_rst_cycles", 128'(rst_cycles), 128'd8);
        check("e_no_write", 128'(wr_q.size()), 128'd0);
        check("e_line_cnt1", 128'(line_cnt), 128'd0);

        // second vsync rise during the clear pulse restarts it
        rst_cycles = 0;
        video_vs_in = 1'b1; tick();
        video_vs_in = 1'b0; tick();
        video_vs_in = 1'b1; tick();
        video_vs_in = 1'b0;
        wait_rst_done();
        check("f_rst_restart", 128'(rst_cycles), 128'd10);

        // next 4-pixel line packs from lane 0
        send_line(4, 24'h00000A);
        check("g_wr_en", {127'h0, fifo_wr_en}, 128'h1);
        check("g_word", fifo_data_out, 128'h0000000A_0000000B_0000000C_0000000D);
        repeat (4) tick();

        // full-length line in a fresh frame
        video_vs_in = 1'b1; tick();
        video_vs_in = 1'b0;
        wait_rst_done();
        wr_q.delete();
        send_line(2880, 24'h000000);
        repeat (4) tick();
        check("h_line_err", {127'h0, line_err}, 128'h0);
        check("h_wr_count", 128'(wr_q.size()), 128'd720);
        check("h_line_cnt", 128'(line_cnt), 128'd1);
        check("h_overflow", {127'h0, overflow}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
